// File: rtl/count4.sv
// count4: free-running 4-bit counter stepped by an internal prescaled tick.
// Latency: COUNT changes on the edge where the prescaler reaches SEC1_MAX-1.
// Backpressure: none; the counter always runs when RESET is low.
//
// Ports:
//   CLK    in   1  system clock, rising edge
//   RESET  in   1  synchronous, active-high reset
//   COUNT  out  4  registered count value, wraps modulo 16
//   CARRY  out  1  registered one-cycle wrap pulse (only with COUNT4_CARRY_EN)
//
// Build option: define COUNT4_CARRY_EN to add the CARRY output and its logic.
// Parameter SEC1_MAX (>= 1) sets the number of CLK edges per COUNT step.

module count4 #(
    parameter int SEC1_MAX = 50_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [3:0] COUNT
`ifdef COUNT4_CARRY_EN
    ,
    output logic       CARRY
`endif
);

    // $clog2(1) is 0, so the prescaler keeps at least one bit.
    localparam int            PW       = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SEC1_MAX - 1);

    logic [PW-1:0] pre;
    logic          enable;

    // With SEC1_MAX=1 the prescaler sits at 0 and the enable is always high.
    assign enable = (pre == PRE_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre   <= '0;
            COUNT <= 4'h0;
        end else begin
            pre <= enable ? '0 : pre + PW'(1);
            if (enable) begin
                COUNT <= COUNT + 4'd1;
            end
        end
    end

`ifdef COUNT4_CARRY_EN
    // High for the single cycle following the edge that moves COUNT F -> 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CARRY <= 1'b0;
        end else begin
            CARRY <= enable && (COUNT == 4'hF);
        end
    end
`endif

endmodule

// File: tb/tb_count4.sv
// tb_count4: checks count4 with SEC1_MAX=4 (dut_a) and SEC1_MAX=1 (dut_b).
// Latency: every comparison is made 1 ns after the rising edge it follows.
// Backpressure: not applicable; stimulus is a fixed sequence of reset levels.

module tb_count4;

    logic       CLK = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [3:0] count_a;
    logic [3:0] count_b;
`ifdef COUNT4_CARRY_EN
    logic       carry_a;
    logic       carry_b;
`endif

    always #10 CLK = ~CLK;

    count4 #(.SEC1_MAX(4)) dut_a (
        .CLK   (CLK),
        .RESET (rst_a),
        .COUNT (count_a)
`ifdef COUNT4_CARRY_EN
        ,
        .CARRY (carry_a)
`endif
    );

    count4 #(.SEC1_MAX(1)) dut_b (
        .CLK   (CLK),
        .RESET (rst_b),
        .COUNT (count_b)
`ifdef COUNT4_CARRY_EN
        ,
        .CARRY (carry_b)
`endif
    );

    typedef struct {
        logic [3:0] cnt_a;
        logic       cy_a;
        logic [3:0] cnt_b;
        logic       cy_b;
        string      tag;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
    } vec_t;

    exp_t sb[$];
    vec_t tab[11];

    // Edges seen since each DUT's last reset edge (0 on the reset edge itself).
    int n_a = 0;
    int n_b = 0;
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive reset levels for the next edge, push the expectation, then
    // compare once the edge has passed.
    task automatic tick(input logic ra, input logic rb, input string tag,
                        input bit use_tab, input logic [3:0] tab_cnt);
        exp_t e;
        exp_t got;
        rst_a = ra;
        rst_b = rb;
        n_a   = ra ? 0 : n_a + 1;
        n_b   = rb ? 0 : n_b + 1;
        e.cnt_a = use_tab ? tab_cnt : 4'((n_a / 4) % 16);
        e.cy_a  = (n_a > 0) && (n_a % 64 == 0);
        e.cnt_b = 4'(n_b % 16);
        e.cy_b  = (n_b > 0) && (n_b % 16 == 0);
        e.tag   = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            got = sb.pop_front();
            chk({got.tag, "_count_a"}, int'(count_a), int'(got.cnt_a));
            chk({got.tag, "_count_b"}, int'(count_b), int'(got.cnt_b));
`ifdef COUNT4_CARRY_EN
            chk({got.tag, "_carry_a"}, int'(carry_a), int'(got.cy_a));
            chk({got.tag, "_carry_b"}, int'(carry_b), int'(got.cy_b));
`endif
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;

        // T1: three reset edges; T2: release, first step on 4th edge, second on 8th.
        tab[0]  = '{1'b1, 4'd0};
        tab[1]  = '{1'b1, 4'd0};
        tab[2]  = '{1'b1, 4'd0};
        tab[3]  = '{1'b0, 4'd0};
        tab[4]  = '{1'b0, 4'd0};
        tab[5]  = '{1'b0, 4'd0};
        tab[6]  = '{1'b0, 4'd1};
        tab[7]  = '{1'b0, 4'd1};
        tab[8]  = '{1'b0, 4'd1};
        tab[9]  = '{1'b0, 4'd1};
        tab[10] = '{1'b0, 4'd2};

        for (int i = 0; i < 11; i++) begin
            tick(tab[i].rst, 1'b1, $sformatf("tab%0d", i), 1'b1, tab[i].cnt);
        end

        // T3: keep running to edge 64; F at edge 60, wrap to 0 at edge 64.
        while (n_a < 64) begin
            tick(1'b0, 1'b1, "t3", 1'b0, 4'd0);
            if (n_a == 60) chk("t3_at_f", int'(count_a), 15);
        end
        chk("t3_wrap", int'(count_a), 0);

        // T4: reach COUNT=5 two edges into a period, then pulse reset once.
        tick(1'b1, 1'b1, "t4_rst", 1'b0, 4'd0);
        repeat (22) tick(1'b0, 1'b1, "t4_run", 1'b0, 4'd0);
        chk("t4_at5", int'(count_a), 5);
        tick(1'b1, 1'b1, "t4_pulse", 1'b0, 4'd0);
        chk("t4_cleared", int'(count_a), 0);
        repeat (3) tick(1'b0, 1'b1, "t4_post", 1'b0, 4'd0);
        chk("t4_no_early_step", int'(count_a), 0);
        tick(1'b0, 1'b1, "t4_step", 1'b0, 4'd0);
        chk("t4_full_period", int'(count_a), 1);

        // T5 (dut_b, step every edge) and T6 (dut_a, 80 periods) together.
        tick(1'b1, 1'b1, "t56_rst", 1'b0, 4'd0);
        repeat (320) begin
            tick(1'b0, 1'b0, "t56", 1'b0, 4'd0);
            if (n_b == 1)  chk("t5_first", int'(count_b), 1);
            if (n_b == 16) chk("t5_wrap", int'(count_b), 0);
        end
        chk("t6_five_wraps", int'(count_a), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
